// File: rtl/song_sequencer_if.sv
// song_sequencer_if: control, ROM and note-player signals of the song sequencer
interface song_sequencer_if #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int SONG_W = 2,
    parameter int IDX_W  = 5
);
    logic                      play;
    logic                      next_song;
    logic                      note_done;
    logic [SONG_W+IDX_W-1:0]   rom_addr;
    logic [NOTE_W+DUR_W-1:0]   rom_data;
    logic                      new_note;
    logic [NOTE_W-1:0]         note;
    logic [DUR_W-1:0]          duration;
    logic                      song_done;
    logic [SONG_W-1:0]         current_song;
    modport slave (
        input  play, next_song, note_done, rom_data,
        output rom_addr, new_note, note, duration, song_done, current_song
    );
    modport master (
        output play, next_song, note_done, rom_data,
        input  rom_addr, new_note, note, duration, song_done, current_song
    );
endinterface

// File: rtl/song_sequencer.sv
// song_sequencer: walks a song ROM and hands each note to the note player
module song_sequencer #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int SONG_W = 2,
    parameter int IDX_W  = 5
) (
    input  logic            clk,
    input  logic            reset,
    song_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, WAIT_DONE, ADVANCE, END} state_t;
    state_t              r_state, w_state;
    logic [IDX_W-1:0]    r_idx, w_idx;
    logic [SONG_W-1:0]   r_song, w_song;
    logic [NOTE_W-1:0]   r_note, w_note, w_rom_note;
    logic [DUR_W-1:0]    r_dur, w_dur, w_rom_dur;
    logic                r_new_note, w_new_note, r_song_done, w_song_done;
    assign {w_rom_note, w_rom_dur} = bus.rom_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_song      <= '0;
            r_note      <= '0;
            r_dur       <= '0;
            r_new_note  <= 1'b0;
            r_song_done <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_idx       <= w_idx;
            r_song      <= w_song;
            r_note      <= w_note;
            r_dur       <= w_dur;
            r_new_note  <= w_new_note;
            r_song_done <= w_song_done;
        end
    end
    // next_song preempts every state and swallows a coincident note_done
    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_song      = r_song;
        w_note      = r_note;
        w_dur       = r_dur;
        w_new_note  = 1'b0;
        w_song_done = 1'b0;
        if (bus.next_song) begin
            w_song  = r_song + 1'b1;
            w_idx   = '0;
            w_state = bus.play ? FETCH : IDLE;
        end else begin
            case (r_state)
                IDLE:      w_state = bus.play ? FETCH : IDLE;
                FETCH:     w_state = bus.play ? DECODE : IDLE;
                DECODE: begin
                    if (w_rom_dur == '0) begin
                        w_state = END;
                    end else begin
                        w_note     = w_rom_note;
                        w_dur      = w_rom_dur;
                        w_new_note = 1'b1;
                        w_state    = WAIT_DONE;
                    end
                end
                WAIT_DONE: w_state = bus.note_done ? ADVANCE : WAIT_DONE;
                ADVANCE: begin
                    w_idx   = &r_idx ? r_idx : r_idx + 1'b1;
                    w_state = &r_idx ? END : FETCH;
                end
                END: begin
                    w_song_done = 1'b1;
                    w_idx       = '0;
                    w_state     = bus.play ? FETCH : IDLE;
                end
                default:   w_state = IDLE;
            endcase
        end
    end
    assign bus.rom_addr     = {r_song, r_idx};
    assign bus.new_note     = r_new_note;
    assign bus.note         = r_note;
    assign bus.duration     = r_dur;
    assign bus.song_done    = r_song_done;
    assign bus.current_song = r_song;
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: cycle table plus scoreboarded note checks for song_sequencer
module tb_song_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [11:0] rom [128];
    logic [11:0] exp_q [$];
    logic prev_nn = 1'b0;
    logic prev_sd = 1'b0;

    song_sequencer_if bus ();
    song_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    typedef struct {
        logic       rst, play, ns, nd, e_nn, e_sd;
        logic [6:0] e_addr;
    } vec_t;
    vec_t vt [18];

    function automatic vec_t v(input logic rst, play, ns, nd, nn, sd, input logic [6:0] addr);
        return '{rst, play, ns, nd, nn, sd, addr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input bit sd, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(sd ? bus.song_done : bus.new_note) && n < 20);
    endtask

    task automatic pulse_nd();
        bus.note_done = 1'b1;
        step();
        bus.note_done = 1'b0;
    endtask

    task automatic pulse_ns();
        bus.next_song = 1'b1;
        step();
        bus.next_song = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.new_note || bus.song_done)
            check("strobe_width", {29'd0, prev_nn & bus.new_note, prev_sd & bus.song_done,
                                   bus.new_note & bus.song_done}, 0);
        if (bus.new_note) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_new_note: got note %0d, expected no strobe at %0t", bus.note, $time);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                check("note", bus.note, e[11:6]);
                check("duration", bus.duration, e[5:0]);
            end
        end
        prev_nn = bus.new_note;
        prev_sd = bus.song_done;
    end

    initial begin
        int n;
        bus.play = 1'b1;
        bus.next_song = 1'b0;
        bus.note_done = 1'b0;
        for (int i = 0; i < 128; i++) rom[i] = '0;
        rom[0]  = {6'd5, 6'd12};
        rom[1]  = {6'd7, 6'd3};
        for (int i = 0; i < 32; i++) rom[32+i] = {6'(i), 6'(i + 1)};
        rom[64] = {6'd9, 6'd2};
        rom[96] = {6'd11, 6'd4};

        vt[0]  = v(1, 1, 0, 0, 0, 0, 0);
        vt[1]  = v(1, 1, 0, 0, 0, 0, 0);
        vt[2]  = v(0, 0, 0, 1, 0, 0, 0);
        vt[3]  = v(0, 1, 0, 0, 0, 0, 0);
        vt[4]  = v(0, 1, 0, 1, 0, 0, 0);
        vt[5]  = v(0, 1, 0, 0, 1, 0, 0);
        vt[6]  = v(0, 1, 0, 0, 0, 0, 0);
        vt[7]  = v(0, 1, 0, 1, 0, 0, 0);
        vt[8]  = v(0, 1, 0, 0, 0, 0, 1);
        vt[9]  = v(0, 1, 0, 0, 0, 0, 1);
        vt[10] = v(0, 1, 0, 0, 1, 0, 1);
        vt[11] = v(0, 1, 0, 1, 0, 0, 1);
        vt[12] = v(0, 1, 0, 0, 0, 0, 2);
        vt[13] = v(0, 1, 0, 0, 0, 0, 2);
        vt[14] = v(0, 1, 0, 0, 0, 0, 2);
        vt[15] = v(0, 1, 0, 0, 0, 1, 0);
        vt[16] = v(0, 1, 0, 0, 0, 0, 0);
        vt[17] = v(0, 1, 0, 0, 1, 0, 0);
        exp_q.push_back({6'd5, 6'd12});
        exp_q.push_back({6'd7, 6'd3});
        exp_q.push_back({6'd5, 6'd12});

        for (int i = 0; i < 18; i++) begin
            reset = vt[i].rst;
            bus.play = vt[i].play;
            bus.next_song = vt[i].ns;
            bus.note_done = vt[i].nd;
            step();
            check($sformatf("row%0d_new_note", i), bus.new_note, vt[i].e_nn);
            check($sformatf("row%0d_song_done", i), bus.song_done, vt[i].e_sd);
            check($sformatf("row%0d_rom_addr", i), bus.rom_addr, vt[i].e_addr);
            check($sformatf("row%0d_song", i), bus.current_song, 0);
            if (vt[i].rst) check($sformatf("row%0d_note_dur", i), {bus.note, bus.duration}, 0);
        end
        bus.note_done = 1'b0;

        // pause: play drops during ADVANCE, idx must survive the trip through IDLE
        pulse_nd();
        bus.play = 1'b0;
        repeat (4) step();
        check("pause_idx_held", bus.rom_addr, 1);
        exp_q.push_back({6'd7, 6'd3});
        bus.play = 1'b1;
        step();
        wait_for(0, n);
        check("resume_latency", n, 2);

        pulse_ns();
        check("next_song_song", bus.current_song, 1);
        check("next_song_addr", bus.rom_addr, 32);
        exp_q.push_back({6'd0, 6'd1});
        wait_for(0, n);
        check("next_song_latency", n, 2);

        for (int i = 1; i < 32; i++) begin
            exp_q.push_back({6'(i), 6'(i + 1)});
            pulse_nd();
            wait_for(0, n);
            check($sformatf("advance_latency_%0d", i), n, 3);
        end
        pulse_nd();
        wait_for(1, n);
        check("last_idx_song_done", n, 2);
        check("last_idx_wrap_addr", bus.rom_addr, 32);
        exp_q.push_back({6'd0, 6'd1});
        wait_for(0, n);
        check("repeat_latency", n, 2);

        // reset lands while the next note sits in DECODE
        pulse_nd();
        step();
        step();
        check("decode_addr", bus.rom_addr, 33);
        reset = 1'b1;
        step();
        check("reset_outputs", {bus.new_note, bus.song_done, bus.note, bus.duration,
                                bus.current_song, bus.rom_addr}, 0);
        reset = 1'b0;
        bus.play = 1'b0;
        step();
        check("post_reset_idle", {bus.new_note, bus.current_song, bus.rom_addr}, 0);

        repeat (3) pulse_ns();
        check("song3_select", bus.current_song, 3);
        check("song3_addr", bus.rom_addr, 96);
        exp_q.push_back({6'd11, 6'd4});
        bus.play = 1'b1;
        step();
        wait_for(0, n);
        check("song3_latency", n, 2);
        bus.next_song = 1'b1;
        bus.note_done = 1'b1;
        step();
        bus.next_song = 1'b0;
        bus.note_done = 1'b0;
        check("wrap_song", bus.current_song, 0);
        check("wrap_addr", bus.rom_addr, 0);
        exp_q.push_back({6'd5, 6'd12});
        wait_for(0, n);
        check("wrap_latency", n, 2);
        repeat (4) step();
        check("coincident_nd_dropped", bus.rom_addr, 0);
        bus.play = 1'b0;
        repeat (3) step();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
